// File: rtl/aggr_out_writer_if.sv
// Row stream from the aggregator into aggr_out_writer: one packed feature row per handshake.
// Feature 0 occupies the most significant IN_W bits of aggr_data_i.
interface aggr_out_writer_if #(
   parameter int unsigned NUM_FEATURE_OUT = 16,
   parameter int unsigned IN_W            = 32
);
   logic                            aggr_valid_i;
   logic                            aggr_ready_o;
   logic [NUM_FEATURE_OUT*IN_W-1:0] aggr_data_i;

   modport master (output aggr_valid_i, output aggr_data_i, input aggr_ready_o);
   modport slave  (input aggr_valid_i, input aggr_data_i, output aggr_ready_o);
endinterface

// File: rtl/aggr_out_writer.sv
// GAT output stage: rescales/saturates aggregated rows and writes them word by word into BRAM.
// Optional build macro AGGR_OUT_RELU_EN applies ReLU after saturation.
module aggr_out_writer #(
   parameter int unsigned NUM_FEATURE_OUT = 16,
   parameter int unsigned IN_W            = 32,
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned FRAC_SHIFT      = 8,
   parameter int unsigned TOTAL_NODES     = 2708,
   parameter int unsigned OUT_ADDR_W      = $clog2(TOTAL_NODES*NUM_FEATURE_OUT)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clr_i,
   aggr_out_writer_if.slave                   aggr,
   output logic [DATA_WIDTH-1:0]              out_BRAM_din,
   output logic                               out_BRAM_ena,
   output logic [OUT_ADDR_W-1:0]              out_BRAM_addra,
   output logic [$clog2(TOTAL_NODES+1)-1:0]   node_cnt_o,
   output logic                               layer_done_o
);

   localparam int unsigned ColW = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
   localparam int unsigned CntW = $clog2(TOTAL_NODES+1);

   localparam logic signed [IN_W-1:0] SatMax =
      {{(IN_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [IN_W-1:0] SatMin =
      {{(IN_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

   state_e                  state_q;
   logic [ColW-1:0]         col_q;
   logic [ColW-1:0]         col_nxt;
   logic [CntW-1:0]         node_cnt_q;
   logic                    ena_q;
   logic                    done_q;
   logic [DATA_WIDTH-1:0]   din_q;
   logic [OUT_ADDR_W-1:0]   addr_q;
   logic [1:0]              rst_sync_q;
   logic signed [IN_W-1:0]  row_q   [NUM_FEATURE_OUT];
   logic signed [IN_W-1:0]  in_word [NUM_FEATURE_OUT];
   logic                    last_col;
   logic                    last_row;
   logic                    hs;

   function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [IN_W-1:0] s);
      logic signed [IN_W-1:0] sh;
      logic signed [IN_W-1:0] r;
      sh = s >>> FRAC_SHIFT;
      r  = sh;
      if (sh > SatMax) begin
         r = SatMax;
      end else if (sh < SatMin) begin
         r = SatMin;
      end
`ifdef AGGR_OUT_RELU_EN
      if (r[IN_W-1]) begin
         r = '0;
      end
`endif
      return r[DATA_WIDTH-1:0];
   endfunction

   // Release is synchronised so no handshake can be taken on a metastable edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_FEATURE_OUT; i++) begin
         in_word[i] = aggr.aggr_data_i[(NUM_FEATURE_OUT-1-i)*IN_W +: IN_W];
      end
   end

   assign col_nxt  = col_q + 1'b1;
   assign last_col = (col_q == ColW'(NUM_FEATURE_OUT-1));
   assign last_row = (node_cnt_q == CntW'(TOTAL_NODES-1));

   // Accepting on the last beat of a row keeps back-to-back rows bubble-free.
   assign aggr.aggr_ready_o = rst_sync_q[1] && !clr_i &&
                              ((state_q == StIdle) ||
                               ((state_q == StWrite) && last_col && !last_row));
   assign hs = aggr.aggr_valid_i && aggr.aggr_ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         col_q      <= '0;
         node_cnt_q <= '0;
         ena_q      <= 1'b0;
         done_q     <= 1'b0;
         din_q      <= '0;
         addr_q     <= '0;
         for (int i = 0; i < NUM_FEATURE_OUT; i++) row_q[i] <= '0;
      end else if (clr_i) begin
         state_q    <= StIdle;
         col_q      <= '0;
         node_cnt_q <= '0;
         ena_q      <= 1'b0;
         done_q     <= 1'b0;
         din_q      <= '0;
         addr_q     <= '0;
         for (int i = 0; i < NUM_FEATURE_OUT; i++) row_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ena_q <= 1'b0;
               if (hs) begin
                  for (int i = 0; i < NUM_FEATURE_OUT; i++) row_q[i] <= in_word[i];
                  col_q   <= '0;
                  ena_q   <= 1'b1;
                  addr_q  <= OUT_ADDR_W'(node_cnt_q) * OUT_ADDR_W'(NUM_FEATURE_OUT);
                  din_q   <= scale(in_word[0]);
                  state_q <= StWrite;
               end
            end
            StWrite: begin
               if (!last_col) begin
                  col_q  <= col_nxt;
                  addr_q <= addr_q + 1'b1;
                  din_q  <= scale(row_q[col_nxt]);
               end else begin
                  node_cnt_q <= node_cnt_q + 1'b1;
                  if (last_row) begin
                     ena_q   <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else if (hs) begin
                     for (int i = 0; i < NUM_FEATURE_OUT; i++) row_q[i] <= in_word[i];
                     col_q  <= '0;
                     addr_q <= addr_q + 1'b1;
                     din_q  <= scale(in_word[0]);
                  end else begin
                     ena_q   <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            StDone: begin
               ena_q <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign out_BRAM_din   = din_q;
   assign out_BRAM_ena   = ena_q;
   assign out_BRAM_addra = addr_q;
   assign node_cnt_o     = node_cnt_q;
   assign layer_done_o   = done_q;

endmodule

// File: tb/tb_aggr_out_writer.sv
// Bench for aggr_out_writer: fixed arithmetic table, hand-built corner sequences and random
// rows checked against a queue-based write model.
module tb_aggr_out_writer;

   localparam int NF = 16;
   localparam int IW = 32;
   localparam int DW = 16;
   localparam int FS = 8;
   localparam int TN = 4;
   localparam int AW = $clog2(TN*NF);
   localparam int CW = $clog2(TN+1);
   localparam int RW = NF*IW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic [DW-1:0] din;
   logic          ena;
   logic [AW-1:0] addra;
   logic [CW-1:0] node_cnt;
   logic          done;

   aggr_out_writer_if #(.NUM_FEATURE_OUT(NF), .IN_W(IW)) aif ();

   aggr_out_writer #(
      .NUM_FEATURE_OUT(NF), .IN_W(IW), .DATA_WIDTH(DW), .FRAC_SHIFT(FS), .TOTAL_NODES(TN)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clr_i          (clr),
      .aggr           (aif.slave),
      .out_BRAM_din   (din),
      .out_BRAM_ena   (ena),
      .out_BRAM_addra (addra),
      .node_cnt_o     (node_cnt),
      .layer_done_o   (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] din;} wr_t;
   typedef struct {logic [IW-1:0] sum; logic [DW-1:0] exp_din;} vec_t;

   wr_t  exp_q[$];
   vec_t tbl[NF];
   int   n_cmp = 0;
   int   n_err = 0;
   int   wr_cnt = 0;
   int   exp_row = 0;
   int   settle = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Floor division by 2^FS, clamp, optional ReLU -- straight from the arithmetic rules.
   function automatic logic [DW-1:0] model(input logic [IW-1:0] s);
      longint v, q, d, lim;
      v   = longint'(signed'(s));
      d   = longint'(1) << FS;
      lim = longint'(1) << (DW-1);
      if (v >= 0) q = v / d;
      else        q = -((-v + d - 1) / d);
      if (q > lim - 1) q = lim - 1;
      if (q < -lim)    q = -lim;
`ifdef AGGR_OUT_RELU_EN
      if (q < 0) q = 0;
`endif
      return DW'(q);
   endfunction

   function automatic logic [DW-1:0] fix_exp(input logic [DW-1:0] e);
`ifdef AGGR_OUT_RELU_EN
      if (e[DW-1]) return '0;
`endif
      return e;
   endfunction

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      logic [IW-1:0] w;
      for (int c = 0; c < NF; c++) begin
         case ($urandom_range(0, 3))
            0:       w = $urandom;
            1:       w = $urandom_range(0, 32'h0020_0000) - 32'h0010_0000;
            2:       w = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: w = $urandom_range(0, 32'h0000_0400) + 32'h007F_FE00
                         - (($urandom_range(0, 1) != 0) ? 32'h00FF_FC00 : 32'h0);
         endcase
         r[(NF-1-c)*IW +: IW] = w;
      end
      return r;
   endfunction

   // Scoreboard: pops one expected word per write, checks ready against the model's state.
   always @(negedge clk) begin
      wr_t w;
      if (!rst_n) begin
         exp_q.delete();
         exp_row = 0;
         settle  = 0;
      end else begin
         if (settle < 3) settle++;
         if (ena) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               w = exp_q.pop_front();
               check("sb_addr", addra, w.addr);
               check("sb_din", din, w.din);
            end
         end
         if (settle >= 3)
            check("sb_ready", aif.aggr_ready_o, (!clr && exp_q.size() == 0 && exp_row < TN));
         if (clr) begin
            exp_q.delete();
            exp_row = 0;
         end else if (aif.aggr_valid_i && aif.aggr_ready_o) begin
            check("accept_within_layer", exp_row < TN, 1);
            for (int c = 0; c < NF; c++) begin
               w.addr = AW'(exp_row*NF + c);
               w.din  = model(aif.aggr_data_i[(NF-1-c)*IW +: IW]);
               exp_q.push_back(w);
            end
            exp_row++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic send_row(input logic [RW-1:0] d, input int gap);
      int t;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      aif.aggr_valid_i = 1'b1;
      aif.aggr_data_i  = d;
      t = 0;
      forever begin
         @(negedge clk);
         if (aif.aggr_ready_o) break;
         t++;
         if (t > 100) begin
            check("handshake_timeout", 0, 1);
            aif.aggr_valid_i = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      aif.aggr_valid_i = 1'b0;
      aif.aggr_data_i  = rand_row();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      check("clr_ready_low", aif.aggr_ready_o, 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      check("clr_ena", ena, 0);
      check("clr_node_cnt", node_cnt, 0);
      check("clr_done", done, 0);
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (!done && t < 60) begin
         @(negedge clk);
         t++;
      end
      check(name, done, 1);
   endtask

   initial begin
      logic [RW-1:0] row;
      int base, cnt, first, last, rdy_cnt;
      logic [AW-1:0] first_addr, last_addr;
      bit found;

      tbl[0]  = '{32'h0000_0100, 16'h0001};
      tbl[1]  = '{32'h7FFF_FFFF, 16'h7FFF};
      tbl[2]  = '{32'h8000_0000, 16'h8000};
      tbl[3]  = '{32'h0000_0000, 16'h0000};
      tbl[4]  = '{32'hFFFF_FFFF, 16'hFFFF};
      tbl[5]  = '{32'hFFFF_FF00, 16'hFFFF};
      tbl[6]  = '{32'hFFFF_FEFF, 16'hFFFE};
      tbl[7]  = '{32'h007F_FFFF, 16'h7FFF};
      tbl[8]  = '{32'h0080_0000, 16'h7FFF};
      tbl[9]  = '{32'hFF80_0000, 16'h8000};
      tbl[10] = '{32'hFF7F_FFFF, 16'h8000};
      tbl[11] = '{32'h0000_01FF, 16'h0001};
      tbl[12] = '{32'h0001_2345, 16'h0123};
      tbl[13] = '{32'hFFFE_DCBA, 16'hFEDC};
      tbl[14] = '{32'h00FF_FFFF, 16'h7FFF};
      tbl[15] = '{32'h1234_5678, 16'h7FFF};

      aif.aggr_valid_i = 1'b0;
      aif.aggr_data_i  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ena", ena, 0);
      check("rst_din", din, 0);
      check("rst_addr", addra, 0);
      check("rst_node_cnt", node_cnt, 0);
      check("rst_done", done, 0);
      check("rst_ready", aif.aggr_ready_o, 0);
      rst_n = 1'b1;

      // One row of 0x100 sums -> sixteen writes of 1 at 0..15.
      base = wr_cnt;
      for (int c = 0; c < NF; c++) row[(NF-1-c)*IW +: IW] = 32'h0000_0100;
      send_row(row, 0);
      @(negedge clk);
      check("first_write_ena", ena, 1);
      check("first_write_addr", addra, 0);
      check("first_write_din", din, 16'h0001);
      repeat (18) @(negedge clk);
      check("row1_writes", wr_cnt - base, NF);
      check("row1_node_cnt", node_cnt, 1);
      check("row1_ready_back", aif.aggr_ready_o, 1);

      // Arithmetic table as one row at node 1.
      for (int c = 0; c < NF; c++) row[(NF-1-c)*IW +: IW] = tbl[c].sum;
      @(posedge clk);
      #1;
      send_row(row, 0);
      for (int c = 0; c < NF; c++) begin
         @(negedge clk);
         check("tbl_ena", ena, 1);
         check("tbl_addr", addra, NF + c);
         check("tbl_din", din, fix_exp(tbl[c].exp_din));
      end
      @(posedge clk);
      #1;
      do_clr();

      // Three back-to-back rows with valid held high.
      cnt = 0;
      first = -1;
      last = -1;
      first_addr = '0;
      last_addr = '0;
      fork
         begin
            for (int r = 0; r < 3; r++) send_row(rand_row(), 0);
         end
         begin
            for (int i = 0; i < 70; i++) begin
               @(negedge clk);
               if (ena) begin
                  if (first < 0) begin
                     first = i;
                     first_addr = addra;
                  end
                  last = i;
                  last_addr = addra;
                  cnt++;
               end
            end
         end
      join
      check("b2b_count", cnt, 3*NF);
      check("b2b_no_gap", last - first, 3*NF - 1);
      check("b2b_first_addr", first_addr, 0);
      check("b2b_last_addr", last_addr, 3*NF - 1);
      check("b2b_node_cnt", node_cnt, 3);

      // Final row of the layer, then a further valid that must be refused.
      @(posedge clk);
      #1;
      send_row(rand_row(), 0);
      aif.aggr_valid_i = 1'b1;
      aif.aggr_data_i  = rand_row();
      wait_done("done_reached");
      check("done_node_cnt", node_cnt, TN);
      cnt = 0;
      rdy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ena) cnt++;
         if (aif.aggr_ready_o) rdy_cnt++;
      end
      check("done_no_write", cnt, 0);
      check("done_no_ready", rdy_cnt, 0);
      check("done_level", done, 1);

      // Clear in DONE with valid still high: refused during clear, accepted right after.
      @(posedge clk);
      #1;
      clr = 1'b1;
      @(negedge clk);
      check("clr_in_done_ready", aif.aggr_ready_o, 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      @(negedge clk);
      check("post_clr_done", done, 0);
      check("post_clr_ready", aif.aggr_ready_o, 1);
      @(posedge clk);
      #1;
      aif.aggr_valid_i = 1'b0;
      @(negedge clk);
      check("post_clr_ena", ena, 1);
      check("post_clr_addr", addra, 0);
      repeat (20) @(posedge clk);
      #1;
      do_clr();

      // Reset in the middle of row 0.
      send_row(rand_row(), 0);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (ena && addra == AW'(5)) found = 1'b1;
      end
      check("reach_col5", found, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_ena", ena, 0);
      check("midrst_addr", addra, 0);
      check("midrst_din", din, 0);
      check("midrst_ready", aif.aggr_ready_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_row(rand_row(), 0);
      @(negedge clk);
      check("rst_restart_ena", ena, 1);
      check("rst_restart_addr", addra, 0);
      repeat (20) @(posedge clk);
      #1;
      do_clr();

      // Random rows and gaps across several layers.
      for (int l = 0; l < 3; l++) begin
         for (int r = 0; r < TN; r++) send_row(rand_row(), $urandom_range(0, 3));
         wait_done("rand_done");
         check("rand_node_cnt", node_cnt, TN);
         @(posedge clk);
         #1;
         do_clr();
      end

      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
